// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath:
// instruction fields and zero flag in, write enables, mux selects and debug taps out.
interface multicycle_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_we;
    logic             ir_we;
    logic             reg_we;
    logic             mem_we;
    logic [1:0]       npc_sel;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic             ext_op;
    logic [2:0]       alu_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero,
        output pc_we, ir_we, reg_we, mem_we, npc_sel, reg_dst, wd_sel,
               alu_src, ext_op, alu_op, state, retired
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_we, ir_we, reg_we, mem_we, npc_sel, reg_dst, wd_sel,
               alu_src, ext_op, alu_op, state, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/exec/mem/wb,
// drives datapath enables and selects, and counts retired instructions.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] FN_ADDU  = OP_W'(6'b100001);
    localparam logic [OP_W-1:0] FN_SUBU  = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] FN_JR    = OP_W'(6'b001000);

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_LUI = ALU_W'(3);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic is_alu_wb;
    logic pc_we_c, ir_we_c, reg_we_c, mem_we_c;
    logic retire_c;

    // Instruction decode; anything unmatched falls through as a NOP
    always_comb begin
        is_addu   = (bus.opcode == OP_RTYPE) && (bus.funct == FN_ADDU);
        is_subu   = (bus.opcode == OP_RTYPE) && (bus.funct == FN_SUBU);
        is_jr     = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
        is_ori    = (bus.opcode == OP_ORI);
        is_lui    = (bus.opcode == OP_LUI);
        is_lw     = (bus.opcode == OP_LW);
        is_sw     = (bus.opcode == OP_SW);
        is_beq    = (bus.opcode == OP_BEQ);
        is_jal    = (bus.opcode == OP_JAL);
        is_alu_wb = is_addu | is_subu | is_ori | is_lui;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next state and per-state write enables
    always_comb begin
        state_d  = S_FETCH;
        pc_we_c  = 1'b0;
        ir_we_c  = 1'b0;
        reg_we_c = 1'b0;
        mem_we_c = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_jal) begin
                    pc_we_c  = 1'b1;
                    reg_we_c = 1'b1;
                end else if (is_jr) begin
                    pc_we_c = 1'b1;
                end else if (is_alu_wb | is_lw | is_sw | is_beq) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_we_c = bus.zero;
                end else if (is_lw | is_sw) begin
                    state_d = S_MEM;
                end else if (is_alu_wb) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_we_c = 1'b1;
                end else if (is_lw) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Only completions out of a legal non-fetch state count as retirements
    always_comb begin
        retire_c  = (state_d == S_FETCH) &&
                    ((state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)    || (state_q == S_WB));
        retired_d = retired_q;
        if (retire_c) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Datapath selects follow the opcode decode for the whole instruction
    always_comb begin
        bus.alu_op  = ALU_ADD;
        bus.alu_src = 1'b0;
        bus.ext_op  = 1'b0;
        bus.reg_dst = 2'd0;
        bus.wd_sel  = 2'd0;
        bus.npc_sel = 2'd0;
        if (is_subu | is_beq) begin
            bus.alu_op = ALU_SUB;
        end else if (is_ori) begin
            bus.alu_op = ALU_OR;
        end else if (is_lui) begin
            bus.alu_op = ALU_LUI;
        end
        bus.alu_src = is_ori | is_lui | is_lw | is_sw;
        bus.ext_op  = is_lw | is_sw | is_beq;
        if (is_addu | is_subu) begin
            bus.reg_dst = 2'd1;
        end else if (is_jal) begin
            bus.reg_dst = 2'd2;
        end
        if (is_lw) begin
            bus.wd_sel = 2'd1;
        end else if (is_jal) begin
            bus.wd_sel = 2'd2;
        end
        if (state_q != S_FETCH) begin
            if (is_beq) begin
                bus.npc_sel = 2'd1;
            end else if (is_jal) begin
                bus.npc_sel = 2'd2;
            end else if (is_jr) begin
                bus.npc_sel = 2'd3;
            end
        end
    end

    // Reset holds every write enable low regardless of state
    always_comb begin
        bus.pc_we   = pc_we_c  & ~reset;
        bus.ir_we   = ir_we_c  & ~reset;
        bus.reg_we  = reg_we_c & ~reset;
        bus.mem_we  = mem_we_c & ~reset;
        bus.state   = state_q;
        bus.retired = retired_q;
    end
endmodule
